// File: rtl/mic3_level_meter.sv
// Paces mic3 conversions, captures each 12-bit word, removes the mid-scale offset and
// reports a windowed peak magnitude plus an 8-LED thermometer level.
module mic3_level_meter #(
  parameter int SAMPLE_DIV = 2083,
  parameter int WINDOW     = 1024,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_err_i,
  output logic        read_o,
  input  logic [11:0] audio_i,
  input  logic        new_data_i,
  output logic [11:0] sample_o,
  output logic        sample_valid_o,
  output logic [11:0] peak_o,
  output logic        peak_valid_o,
  output logic [7:0]  level_o,
  output logic        err_timeout_o,
  output logic        err_overrun_o
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  // Two's-complement magnitude; -2048 maps to 0x800 as an unsigned value.
  function automatic logic [11:0] magnitude(input logic [11:0] s);
    magnitude = s[11] ? (12'd0 - s) : s;
  endfunction

  function automatic logic [7:0] thermometer(input logic [11:0] p);
    for (int i = 0; i < 8; i++) begin
      thermometer[i] = (p >= (12'd16 << i));
    end
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   to_q, to_d;
  logic [WW-1:0]   win_q;
  logic [11:0]     acc_q;
  logic            read_q, read_d;
  logic            nd_q;
  logic [11:0]     sample_q;
  logic            sv_q;
  logic [11:0]     peak_q;
  logic            pv_q;
  logic [7:0]      level_q;
  logic            err_to_q;
  logic            err_ov_q;

  logic            tick_s;
  logic            nd_edge_s;
  logic            capture_s;
  logic            timeout_s;
  logic            overrun_s;
  logic [11:0]     sample_d;
  logic [11:0]     mag_s;
  logic [11:0]     win_max_s;

  assign tick_s    = en_i & (cnt_q == DIV_LAST);
  assign nd_edge_s = new_data_i & ~nd_q;
  assign sample_d  = {~audio_i[11], audio_i[10:0]};
  assign mag_s     = magnitude(sample_d);
  assign win_max_s = (mag_s > acc_q) ? mag_s : acc_q;

  // Sample-rate divider next state; disabling parks it at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == DIV_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Request FSM next state: raise read on tick, drop it on data edge or timeout.
  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    to_d      = to_q;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    overrun_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          state_d = ST_WAIT;
          read_d  = 1'b1;
          to_d    = '0;
        end else begin
          read_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        overrun_s = tick_s;
        if (nd_edge_s) begin
          state_d   = ST_IDLE;
          read_d    = 1'b0;
          capture_s = 1'b1;
        end else if (to_q == TO_LAST) begin
          state_d   = ST_IDLE;
          read_d    = 1'b0;
          timeout_s = 1'b1;
        end else begin
          to_d      = to_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        read_d  = 1'b0;
      end
    endcase
  end

  // Control registers: divider, FSM, timeout counter, data-ready history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      read_q  <= 1'b0;
      nd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      read_q  <= read_d;
      nd_q    <= new_data_i;
    end
  end

  // Capture path and peak window; outputs hold between strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= 12'd0;
      sv_q     <= 1'b0;
      peak_q   <= 12'd0;
      pv_q     <= 1'b0;
      level_q  <= 8'd0;
      acc_q    <= 12'd0;
      win_q    <= '0;
    end else if (capture_s) begin
      sample_q <= sample_d;
      sv_q     <= 1'b1;
      if (win_q == WIN_LAST) begin
        peak_q  <= win_max_s;
        level_q <= thermometer(win_max_s);
        pv_q    <= 1'b1;
        acc_q   <= 12'd0;
        win_q   <= '0;
      end else begin
        pv_q    <= 1'b0;
        acc_q   <= win_max_s;
        win_q   <= win_q + WW'(1);
      end
    end else begin
      sv_q <= 1'b0;
      pv_q <= 1'b0;
    end
  end

  // Sticky error flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      if (timeout_s) begin
        err_to_q <= 1'b1;
      end else if (clr_err_i) begin
        err_to_q <= 1'b0;
      end else begin
        err_to_q <= err_to_q;
      end
      if (overrun_s) begin
        err_ov_q <= 1'b1;
      end else if (clr_err_i) begin
        err_ov_q <= 1'b0;
      end else begin
        err_ov_q <= err_ov_q;
      end
    end
  end

  assign read_o         = read_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sv_q;
  assign peak_o         = peak_q;
  assign peak_valid_o   = pv_q;
  assign level_o        = level_q;
  assign err_timeout_o  = err_to_q;
  assign err_overrun_o  = err_ov_q;

endmodule
